// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, stage FSM states, NZP reset value, immediate sign extension.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [2:0] NZP_RESET_DEFAULT = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_AND,
    ALU_NOT
  } alu_op_t;

  function automatic logic [15:0] sext5(input logic [4:0] imm);
    return {{11{imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/lc3_alu.sv
// Combinational LC-3 operate ALU: result of ADD/AND/NOT plus the condition codes it would set.
// Zero latency; no flow control.
module lc3_alu
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp_next
);

  always_comb begin
    case (op)
      ALU_AND: result = a & b;
      ALU_NOT: result = ~a;
      default: result = a + b;
    endcase

    if (result[WIDTH-1])     nzp_next = 3'b100;
    else if (result == '0)   nzp_next = 3'b010;
    else                     nzp_next = 3'b001;
  end

endmodule

// File: rtl/lc3_operate_exec.sv
// LC-3 ADD/AND/NOT execute/writeback stage owning NZP; STRICT_DECODE_EN rejects nonzero reserved fields.
// Accept-to-WB 3 cycles, one instruction per 4 cycles; instr_ready only in IDLE, nothing buffered.
module lc3_operate_exec
  import lc3_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [2:0] NZP_RESET = NZP_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [2:0]       SR0,
  output logic [2:0]       SR1,
  input  logic [WIDTH-1:0] rf_out0,
  input  logic [WIDTH-1:0] rf_out1,
  output logic [WIDTH-1:0] Bus,
  output logic [2:0]       DR,
  output logic             WE,
  output logic [2:0]       nzp,
  output logic             done,
  output logic             illegal
);

  state_t           state, state_nxt;
  logic [15:0]      ir;
  logic [WIDTH-1:0] op_a, op_b, res_q;
  logic [WIDTH-1:0] alu_b, alu_res;
  logic [2:0]       alu_nzp, nzp_q, nzp_r;
  alu_op_t          alu_op;
  logic             accept, legal;

  assign accept = instr_valid & instr_ready;

  always_comb begin
    case (instr[15:12])
      OP_ADD, OP_AND, OP_NOT: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
`ifdef STRICT_DECODE_EN
    if (instr[15:12] == OP_NOT && instr[5:0] != 6'b111111)
      legal = 1'b0;
    if ((instr[15:12] == OP_ADD || instr[15:12] == OP_AND) && !instr[5] && instr[4:3] != 2'b00)
      legal = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = legal ? ST_READ : ST_ERR;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == ST_IDLE) & ~reset;
    WE          = (state == ST_WB);
    done        = (state == ST_WB);
    illegal     = (state == ST_ERR);
    Bus         = (state == ST_WB) ? res_q : '0;
  end

  assign SR0 = ir[8:6];
  assign SR1 = ir[2:0];
  assign DR  = ir[11:9];
  assign nzp = nzp_r;

  always_comb begin
    case (ir[15:12])
      OP_AND:  alu_op = ALU_AND;
      OP_NOT:  alu_op = ALU_NOT;
      default: alu_op = ALU_ADD;
    endcase
    alu_b = ir[5] ? WIDTH'($signed(sext5(ir[4:0]))) : op_b;
  end

  lc3_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (op_a),
    .b        (alu_b),
    .op       (alu_op),
    .result   (alu_res),
    .nzp_next (alu_nzp)
  );

  // nzp_q holds the codes of the pending result; they only reach nzp_r when WB commits
  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res_q <= '0;
      nzp_q <= NZP_RESET;
      nzp_r <= NZP_RESET;
    end else begin
      if (accept) ir <= instr;
      if (state == ST_READ) begin
        op_a <= rf_out0;
        op_b <= rf_out1;
      end
      if (state == ST_EXEC) begin
        res_q <= alu_res;
        nzp_q <= alu_nzp;
      end
      if (state == ST_WB) nzp_r <= nzp_q;
    end
  end

endmodule

// File: tb/tb_lc3_operate_exec.sv
// Bench for lc3_operate_exec: directed vector table, reset abort sequence, random run against a reference model.
module tb_lc3_operate_exec;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, instr_valid, instr_ready;
  logic [15:0] instr;
  logic [2:0]  SR0, SR1, DR, nzp;
  logic [15:0] rf_out0, rf_out1, Bus;
  logic        WE, done, illegal;

  lc3_operate_exec dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .SR0         (SR0),
    .SR1         (SR1),
    .rf_out0     (rf_out0),
    .rf_out1     (rf_out1),
    .Bus         (Bus),
    .DR          (DR),
    .WE          (WE),
    .nzp         (nzp),
    .done        (done),
    .illegal     (illegal)
  );

  // Environment register file: combinational reads, write on WE, bench preload port
  logic [15:0] rf [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_dat;
  assign rf_out0 = rf[SR0];
  assign rf_out1 = rf[SR1];
  always @(posedge clk) begin
    if (WE)         rf[DR]      <= Bus;
    else if (pl_en) rf[pl_addr] <= pl_dat;
  end

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] ref_rf [8];
  logic [2:0]  exp_nzp;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] bus;
    logic [2:0]  dr;
    logic        ill;
    logic [2:0]  nzp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge.
  task automatic preload(input logic [2:0] a, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = a; pl_dat = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_rf[a] = v;
  endtask

  // Reference: LC-3 operate semantics computed from the instruction fields.
  task automatic model(input logic [15:0] ins, output logic [15:0] bus, output logic ill, output logic [2:0] cc);
    logic [15:0] a, b;
    logic [3:0]  op;
    op  = ins[15:12];
    a   = ref_rf[ins[8:6]];
    b   = ins[5] ? {{11{ins[4]}}, ins[4:0]} : ref_rf[ins[2:0]];
    ill = !(op == 4'b0001 || op == 4'b0101 || op == 4'b1001);
`ifdef STRICT_DECODE_EN
    if (op == 4'b1001 && ins[5:0] != 6'h3f) ill = 1'b1;
    if ((op == 4'b0001 || op == 4'b0101) && !ins[5] && ins[4:3] != 2'b00) ill = 1'b1;
`endif
    if (op == 4'b0001)      bus = 16'((32'(a) + 32'(b)) % 65536);
    else if (op == 4'b0101) bus = a & b;
    else                    bus = 16'hFFFF - a;
    if (ill)                   cc = exp_nzp;
    else if (bus == 16'h0000)  cc = 3'b010;
    else if ($signed(bus) < 0) cc = 3'b100;
    else                       cc = 3'b001;
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge afterwards.
  task automatic exec(input logic [15:0] ins, input logic [15:0] e_bus, input logic [2:0] e_dr,
                      input logic e_ill, input logic [2:0] e_nzp);
    int n;
    bit hit;
    chk("ready_idle", 32'(instr_ready), 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = 16'($urandom);   // valid stays high with junk: must be ignored
    hit = 1'b0;
    n = 0;
    while (!hit && n < 6) begin
      @(negedge clk);
      n++;
      if (WE || illegal) hit = 1'b1;
    end
    instr_valid = 1'b0;
    if (!hit) chk("timeout", 0, 1);
    else if (e_ill) begin
      chk("illegal", 32'(illegal), 1);
      chk("illegal_latency", 32'(n), 1);
      chk("we_in_err", 32'(WE), 0);
    end else begin
      chk("wb_latency", 32'(n), 3);
      chk("bus", 32'(Bus), 32'(e_bus));
      chk("dr", 32'(DR), 32'(e_dr));
      chk("done", 32'(done), 1);
      chk("illegal_in_wb", 32'(illegal), 0);
    end
    @(negedge clk);
    chk("nzp", 32'(nzp), 32'(e_nzp));
    chk("we_after", 32'(WE), 0);
    chk("bus_after", 32'(Bus), 0);
    if (!e_ill) chk("rf_written", 32'(rf[e_dr]), 32'(e_bus));
  endtask

  initial begin
    logic [15:0] ebus;
    logic        eill;
    logic [2:0]  ecc;
    logic [15:0] ins;
    int          k;
    bit          we_seen;

    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; pl_en = 1'b0; pl_addr = 3'd0; pl_dat = 16'h0;
    exp_nzp = 3'b010;
    repeat (2) @(negedge clk);

    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_we", 32'(WE), 0);
    chk("rst_bus", 32'(Bus), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_nzp", 32'(nzp), 32'(3'b010));
    chk("rst_addr", 32'({SR0, SR1, DR}), 0);
    reset = 1'b0;
    @(negedge clk);

    preload(3'd0, 16'h0005);
    preload(3'd1, 16'h0003);
    preload(3'd3, 16'h0000);
    preload(3'd4, 16'h1234);
    preload(3'd6, 16'h00FF);

    tbl.push_back('{16'h1401, 16'h0008, 3'd2, 1'b0, 3'b001});
    tbl.push_back('{16'h16FF, 16'hFFFF, 3'd3, 1'b0, 3'b100});
    tbl.push_back('{16'h5920, 16'h0000, 3'd4, 1'b0, 3'b010});
    tbl.push_back('{16'h9BBF, 16'hFF00, 3'd5, 1'b0, 3'b100});
    tbl.push_back('{16'h1F61, 16'hFF01, 3'd7, 1'b0, 3'b100});
    tbl.push_back('{16'h0000, 16'h0000, 3'd0, 1'b1, 3'b100});
`ifdef STRICT_DECODE_EN
    tbl.push_back('{16'h9BBE, 16'h0000, 3'd0, 1'b1, 3'b100});
    tbl.push_back('{16'h1419, 16'h0000, 3'd0, 1'b1, 3'b100});
`else
    tbl.push_back('{16'h9BBE, 16'hFF00, 3'd5, 1'b0, 3'b100});
    tbl.push_back('{16'h1419, 16'h0008, 3'd2, 1'b0, 3'b001});
`endif
    for (int i = 0; i < tbl.size(); i++)
      exec(tbl[i].ins, tbl[i].bus, tbl[i].dr, tbl[i].ill, tbl[i].nzp);

    // Reset asserted during EXEC abandons the instruction
    chk("ready_before_abort", 32'(instr_ready), 1);
    instr = 16'h1401;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(WE), 0);
    chk("abort_ready_in_reset", 32'(instr_ready), 0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", 32'(instr_ready), 1);
    we_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (WE) we_seen = 1'b1;
    end
    chk("abort_no_we", 32'(we_seen), 0);
    chk("abort_nzp", 32'(nzp), 32'(3'b010));
    exp_nzp = 3'b010;

    // Randomised run against the reference model
    for (int r = 0; r < 8; r++) preload(3'(r), 16'($urandom));
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      ins = 16'($urandom);
      if (k < 3)      ins[15:12] = 4'b0001;
      else if (k < 6) ins[15:12] = 4'b0101;
      else if (k < 9) ins[15:12] = 4'b1001;
      model(ins, ebus, eill, ecc);
      exec(ins, ebus, ins[11:9], eill, ecc);
      if (!eill) ref_rf[ins[11:9]] = ebus;
      exp_nzp = ecc;
    end
    for (int r = 0; r < 8; r++) chk("final_rf", 32'(rf[r]), 32'(ref_rf[r]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
